axis_to_ext_fifo_wr: RTL and testbench

//  AXI4-Stream slave to GEM external-FIFO RX write-side driver (rx_w_* style: wr/data/sop/eop/status/err/flush).

---
 rtl/axis_to_ext_fifo_wr_pkg.sv | 31 +++
 rtl/axis_to_ext_fifo_wr_gap_timer.sv | 29 ++
 rtl/axis_to_ext_fifo_wr.sv | 149 ++++++++++++++
 tb/tb_axis_to_ext_fifo_wr.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_to_ext_fifo_wr_pkg.sv
// Shared definitions for the external-FIFO RX write side: status word layout
// and write-side FSM encoding.
package axis_to_ext_fifo_wr_pkg;

  localparam int unsigned EXTF_LEN_W      = 14;
  localparam int unsigned EXTF_STATUS_W   = 45;
  localparam int unsigned EXTF_ST_LEN_LSB = 0;
  localparam int unsigned EXTF_ST_LEN_MSB = 13;
  localparam int unsigned EXTF_ST_BAD     = 14;
  localparam int unsigned EXTF_ST_LENERR  = 15;

  typedef enum logic [1:0] {
    EXTF_IDLE = 2'd0,
    EXTF_DATA = 2'd1,
    EXTF_DROP = 2'd2
  } extf_state_t;

  function automatic logic [EXTF_STATUS_W-1:0] extf_status(
    input logic [EXTF_LEN_W-1:0] len,
    input logic                  bad,
    input logic                  lenerr
  );
    logic [EXTF_STATUS_W-1:0] s;
    s                                   = '0;
    s[EXTF_ST_LEN_MSB:EXTF_ST_LEN_LSB]  = len;
    s[EXTF_ST_BAD]                      = bad;
    s[EXTF_ST_LENERR]                   = lenerr;
    return s;
  endfunction

endpackage

// File: rtl/axis_to_ext_fifo_wr_gap_timer.sv
// Write pacing timer: reloads WR_GAP on every accepted beat and counts down;
// o_done is high while the count is zero.
module wr_gap_timer #(
  parameter int unsigned WR_GAP = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  output logic o_done
);

  localparam int unsigned GW = (WR_GAP < 2) ? 1 : $clog2(WR_GAP + 1);
  localparam logic [GW-1:0] LOAD = GW'(WR_GAP);

  logic [GW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/axis_to_ext_fifo_wr.sv
// AXI4-Stream slave driving the GEM external-FIFO RX write interface:
// paced byte writes, end-of-frame status word and overflow frame abort.
module axis_to_ext_fifo_wr
  import axis_to_ext_fifo_wr_pkg::*;
#(
  parameter int unsigned                WR_GAP    = 0,
  parameter logic [EXTF_LEN_W-1:0]      MIN_FRAME = 14'd1,
  parameter logic [EXTF_LEN_W-1:0]      MAX_FRAME = 14'd1518
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic                     w_wr,
  output logic [7:0]               w_data,
  output logic                     w_sop,
  output logic                     w_eop,
  output logic                     w_err,
  output logic [EXTF_STATUS_W-1:0] w_status,
  input  logic                     w_overflow,
  output logic                     w_flush,
  output logic [15:0]              frames_ok_o,
  output logic [15:0]              frames_drop_o
);

  extf_state_t            r_state;
  extf_state_t            w_state_nxt;
  logic [EXTF_LEN_W-1:0]  r_len;
  logic [EXTF_LEN_W-1:0]  w_len_nxt;
  logic [EXTF_LEN_W-1:0]  w_len_inc;
  logic                   w_gap_done;
  logic                   w_accept;
  logic                   w_lenerr;
  logic                   w_do_wr;
  logic                   w_do_sop;
  logic                   w_do_eop;
  logic                   w_do_flush;
  logic                   w_do_drop;

  wr_gap_timer #(
    .WR_GAP (WR_GAP)
  ) u_gap_timer (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_accept),
    .o_done (w_gap_done)
  );

  // DROP drains the rest of the frame as fast as the source offers it.
  assign s_axis_tready = (r_state == EXTF_DROP) | w_gap_done;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_len_inc     = (r_len == '1) ? r_len : r_len + 1'b1;
  assign w_lenerr      = (w_len_nxt < MIN_FRAME) | (w_len_nxt > MAX_FRAME);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= EXTF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_do_wr     = 1'b0;
    w_do_sop    = 1'b0;
    w_do_eop    = 1'b0;
    w_do_flush  = 1'b0;
    w_do_drop   = 1'b0;
    unique case (r_state)
      EXTF_IDLE: begin
        if (w_accept) begin
          w_do_wr   = 1'b1;
          w_do_sop  = 1'b1;
          w_len_nxt = 14'd1;
          if (s_axis_tlast) begin
            w_do_eop = 1'b1;
          end else begin
            w_state_nxt = EXTF_DATA;
          end
        end
      end
      EXTF_DATA: begin
        // Overflow wins over a beat accepted in the same cycle: that byte is
        // discarded too, and a tlast beat closes the aborted frame at once.
        if (w_overflow) begin
          w_do_flush = 1'b1;
          if (w_accept && s_axis_tlast) begin
            w_do_drop   = 1'b1;
            w_state_nxt = EXTF_IDLE;
          end else begin
            w_state_nxt = EXTF_DROP;
          end
        end else if (w_accept) begin
          w_do_wr   = 1'b1;
          w_len_nxt = w_len_inc;
          if (s_axis_tlast) begin
            w_do_eop    = 1'b1;
            w_state_nxt = EXTF_IDLE;
          end
        end
      end
      EXTF_DROP: begin
        if (w_accept && s_axis_tlast) begin
          w_do_drop   = 1'b1;
          w_state_nxt = EXTF_IDLE;
        end
      end
      default: w_state_nxt = EXTF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len         <= '0;
      w_wr          <= 1'b0;
      w_data        <= '0;
      w_sop         <= 1'b0;
      w_eop         <= 1'b0;
      w_err         <= 1'b0;
      w_status      <= '0;
      w_flush       <= 1'b0;
      frames_ok_o   <= '0;
      frames_drop_o <= '0;
    end else begin
      r_len   <= w_len_nxt;
      w_wr    <= w_do_wr;
      w_sop   <= w_do_sop;
      w_eop   <= w_do_eop;
      w_flush <= w_do_flush;
      w_err   <= w_do_eop & (s_axis_tuser | w_lenerr);
      if (w_do_wr) begin
        w_data <= s_axis_tdata;
      end
      if (w_do_eop) begin
        w_status    <= extf_status(w_len_nxt, s_axis_tuser, w_lenerr);
        frames_ok_o <= frames_ok_o + 16'd1;
      end
      if (w_do_drop) begin
        frames_drop_o <= frames_drop_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_to_ext_fifo_wr.sv
// Directed bench for axis_to_ext_fifo_wr: table of frames plus hand sequences
// for overflow abort, write pacing and mid-frame reset.
module tb_axis_to_ext_fifo_wr;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with WR_GAP=0
  logic [7:0]  d_tdata = '0;
  logic        d_tvalid = 1'b0, d_tready, d_tlast = 1'b0, d_tuser = 1'b0;
  logic        d_wr, d_sop, d_eop, d_err, d_ovf = 1'b0, d_flush;
  logic [7:0]  d_data;
  logic [44:0] d_status;
  logic [15:0] d_ok, d_drop;

  axis_to_ext_fifo_wr #(.WR_GAP(0), .MIN_FRAME(14'd1), .MAX_FRAME(14'd1518)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(d_tdata), .s_axis_tvalid(d_tvalid), .s_axis_tready(d_tready),
    .s_axis_tlast(d_tlast), .s_axis_tuser(d_tuser),
    .w_wr(d_wr), .w_data(d_data), .w_sop(d_sop), .w_eop(d_eop), .w_err(d_err),
    .w_status(d_status), .w_overflow(d_ovf), .w_flush(d_flush),
    .frames_ok_o(d_ok), .frames_drop_o(d_drop)
  );

  // DUT with WR_GAP=3
  logic [7:0]  g_tdata = '0;
  logic        g_tvalid = 1'b0, g_tready, g_tlast = 1'b0;
  logic        g_wr, g_sop, g_eop, g_err, g_flush;
  logic [7:0]  g_data;
  logic [44:0] g_status;
  logic [15:0] g_ok, g_drop;

  axis_to_ext_fifo_wr #(.WR_GAP(3)) dut_gap (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(g_tdata), .s_axis_tvalid(g_tvalid), .s_axis_tready(g_tready),
    .s_axis_tlast(g_tlast), .s_axis_tuser(1'b0),
    .w_wr(g_wr), .w_data(g_data), .w_sop(g_sop), .w_eop(g_eop), .w_err(g_err),
    .w_status(g_status), .w_overflow(1'b0), .w_flush(g_flush),
    .frames_ok_o(g_ok), .frames_drop_o(g_drop)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor of the WR_GAP=0 write port
  int unsigned m_wr, m_sop, m_eop, m_flush, m_dbad, m_sop_idx, m_eop_idx, m_first, m_last;
  logic [44:0] m_status;
  logic        m_err;

  always @(negedge clk) begin
    if (d_flush) m_flush++;
    if (d_wr) begin
      if (m_wr == 0) m_first = cyc;
      m_last = cyc;
      if (d_data !== m_wr[7:0]) m_dbad++;
      if (d_sop) begin m_sop++; m_sop_idx = m_wr; end
      if (d_eop) begin m_eop++; m_eop_idx = m_wr; m_status = d_status; m_err = d_err; end
      m_wr++;
    end
  end

  // Monitor of the WR_GAP=3 write port
  int unsigned g_wr_n = 0, g_eop_n = 0, g_prev = 0, g_baddiff = 0;
  always @(negedge clk) begin
    if (g_wr) begin
      if (g_wr_n != 0 && (cyc - g_prev) != 4) g_baddiff++;
      g_prev = cyc;
      if (g_eop) g_eop_n++;
      g_wr_n++;
    end
  end

  task automatic clear_mon();
    m_wr = 0; m_sop = 0; m_eop = 0; m_flush = 0; m_dbad = 0;
    m_sop_idx = 32'hFFFF; m_eop_idx = 32'hFFFF; m_first = 0; m_last = 0;
    m_status = '0; m_err = 1'b0;
  endtask

  // One beat on the WR_GAP=0 DUT; called and returns at a negedge.
  task automatic beat(input int unsigned idx, input bit last, input bit user, input bit ovf);
    int unsigned t;
    t = 0;
    d_tdata = idx[7:0]; d_tlast = last; d_tuser = user; d_tvalid = 1'b1; d_ovf = ovf;
    while (!d_tready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_total++;
      $display("FAIL tready_timeout: waited %0d cycles, limit 100", t);
    end
    @(negedge clk);
    d_tvalid = 1'b0; d_tlast = 1'b0; d_tuser = 1'b0; d_ovf = 1'b0;
  endtask

  task automatic send_range(input int unsigned first, input int unsigned lastb,
                            input int unsigned len, input bit user);
    for (int unsigned i = first; i <= lastb; i++) beat(i, (i == len - 1), user, 1'b0);
  endtask

  typedef struct {
    int unsigned len;
    bit          user;
    logic [44:0] exp_status;
    bit          exp_err;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] ok0, drop0;

  initial begin
    tbl[0] = '{len: 64,    user: 1'b0, exp_status: 45'h0040, exp_err: 1'b0};
    tbl[1] = '{len: 1,     user: 1'b1, exp_status: 45'h4001, exp_err: 1'b1};
    tbl[2] = '{len: 1518,  user: 1'b0, exp_status: 45'h05EE, exp_err: 1'b0};
    tbl[3] = '{len: 1519,  user: 1'b0, exp_status: 45'h85EF, exp_err: 1'b1};
    tbl[4] = '{len: 1600,  user: 1'b0, exp_status: 45'h8640, exp_err: 1'b1};
    tbl[5] = '{len: 20000, user: 1'b0, exp_status: 45'hBFFF, exp_err: 1'b1};

    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_wr",     {63'd0, d_wr}, 64'd0);
    check("rst_status", {19'd0, d_status}, 64'd0);
    check("rst_ok",     {48'd0, d_ok}, 64'd0);
    check("rst_flush",  {63'd0, d_flush}, 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[k]) begin
      clear_mon();
      ok0 = d_ok;
      send_range(0, tbl[k].len - 1, tbl[k].len, tbl[k].user);
      repeat (3) @(negedge clk);
      check($sformatf("f%0d_writes", k),   m_wr, tbl[k].len);
      check($sformatf("f%0d_span", k),     m_last - m_first, tbl[k].len - 1);
      check($sformatf("f%0d_sop", k),      {m_sop, m_sop_idx}, {32'd1, 32'd0});
      check($sformatf("f%0d_eop", k),      {m_eop, m_eop_idx}, {32'd1, tbl[k].len - 1});
      check($sformatf("f%0d_data", k),     m_dbad, 0);
      check($sformatf("f%0d_status", k),   {19'd0, m_status}, {19'd0, tbl[k].exp_status});
      check($sformatf("f%0d_err", k),      {63'd0, m_err}, {63'd0, tbl[k].exp_err});
      check($sformatf("f%0d_held", k),     {19'd0, d_status}, {19'd0, tbl[k].exp_status});
      check($sformatf("f%0d_ok", k),       {48'd0, d_ok}, {48'd0, ok0 + 16'd1});
    end

    // Overflow after byte 40 of a 100-byte frame
    clear_mon();
    ok0 = d_ok; drop0 = d_drop;
    send_range(0, 40, 100, 1'b0);
    d_ovf = 1'b1;
    @(negedge clk);
    d_ovf = 1'b0;
    send_range(41, 99, 100, 1'b0);
    repeat (3) @(negedge clk);
    check("ovf_writes", m_wr, 41);
    check("ovf_eop",    m_eop, 0);
    check("ovf_flush",  m_flush, 1);
    check("ovf_drop",   {48'd0, d_drop}, {48'd0, drop0 + 16'd1});
    check("ovf_ok",     {48'd0, d_ok}, {48'd0, ok0});

    clear_mon();
    send_range(0, 3, 4, 1'b0);
    repeat (2) @(negedge clk);
    check("after_ovf_sop", {m_sop, m_sop_idx}, {32'd1, 32'd0});
    check("after_ovf_eop", {m_eop, m_eop_idx}, {32'd1, 32'd3});

    // Overflow coinciding with acceptance of the tlast beat
    clear_mon();
    ok0 = d_ok; drop0 = d_drop;
    send_range(0, 3, 5, 1'b0);
    beat(4, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_last_writes", m_wr, 4);
    check("ovf_last_eop",    m_eop, 0);
    check("ovf_last_flush",  m_flush, 1);
    check("ovf_last_drop",   {48'd0, d_drop}, {48'd0, drop0 + 16'd1});
    check("ovf_last_ok",     {48'd0, d_ok}, {48'd0, ok0});

    // Overflow in the w_eop cycle and while idle is ignored
    clear_mon();
    ok0 = d_ok; drop0 = d_drop;
    send_range(0, 2, 3, 1'b0);
    d_ovf = 1'b1;
    repeat (3) @(negedge clk);
    d_ovf = 1'b0;
    send_range(0, 1, 2, 1'b0);
    repeat (2) @(negedge clk);
    check("eop_ovf_flush", m_flush, 0);
    check("eop_ovf_ok",    {48'd0, d_ok}, {48'd0, ok0 + 16'd2});
    check("eop_ovf_drop",  {48'd0, d_drop}, {48'd0, drop0});
    check("eop_ovf_eops",  m_eop, 2);

    // WR_GAP=3 pacing with tvalid held high
    begin
      int unsigned low_cnt;
      int unsigned t;
      low_cnt = 0;
      g_tvalid = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
        g_tdata = i[7:0]; g_tlast = (i == 7);
        t = 0;
        while (!g_tready && t < 100) begin low_cnt++; t++; @(negedge clk); end
        if (t >= 100) begin
          n_total++;
          $display("FAIL gap_tready_timeout: waited %0d cycles, limit 100", t);
        end
        @(negedge clk);
      end
      g_tvalid = 1'b0; g_tlast = 1'b0;
      repeat (3) @(negedge clk);
      check("gap_writes",    g_wr_n, 8);
      check("gap_spacing",   g_baddiff, 0);
      check("gap_tready_lo", low_cnt, 21);
      check("gap_eop",       g_eop_n, 1);
    end

    // Asynchronous reset in the middle of a 50-byte frame
    send_range(0, 9, 50, 1'b0);
    check("pre_rst_wr", {63'd0, d_wr}, 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_outs",   {d_wr, d_sop, d_eop, d_err, d_flush, d_data}, 64'd0);
    check("arst_status", {19'd0, d_status}, 64'd0);
    check("arst_cnts",   {32'd0, d_ok, d_drop}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_cnts", {32'd0, d_ok, d_drop}, 64'd0);
    clear_mon();
    send_range(0, 2, 3, 1'b0);
    repeat (2) @(negedge clk);
    check("post_rst_sop",    {m_sop, m_sop_idx}, {32'd1, 32'd0});
    check("post_rst_status", {19'd0, m_status}, 64'h3);
    check("post_rst_ok",     {48'd0, d_ok}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
